// File: rtl/exec_pkg.sv
// Shared execute-stage types and EX/MEM buffer field layout.
// The MEM stage uses the same offset helpers to unpack bufferOut.
package exec_pkg;

    typedef enum logic [3:0] {
        OpSub = 4'd0,
        OpAdd = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpCmp = 4'd4,
        OpXor = 4'd5,
        OpShl = 4'd6,
        OpShr = 4'd7,
        OpSra = 4'd8,
        OpMul = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        FwdReg    = 2'd0,
        FwdAlu    = 2'd1,
        FwdRes    = 2'd2,
        FwdRegAlt = 2'd3
    } fwd_sel_t;

    localparam int unsigned CtlBits  = 4;
    localparam int unsigned FlagBits = 4;

    // Layout LSB first: rd3, Rc, Rb, Ra, ctl[4], flags[4], aluResult.
    function automatic int unsigned buf_off_rc(int unsigned n, int unsigned rw);
        return n + 0 * rw;
    endfunction

    function automatic int unsigned buf_off_rb(int unsigned n, int unsigned rw);
        return n + rw;
    endfunction

    function automatic int unsigned buf_off_ra(int unsigned n, int unsigned rw);
        return n + 2 * rw;
    endfunction

    function automatic int unsigned buf_off_ctl(int unsigned n, int unsigned rw);
        return n + 3 * rw;
    endfunction

    function automatic int unsigned buf_off_flags(int unsigned n, int unsigned rw);
        return n + 3 * rw + CtlBits;
    endfunction

    function automatic int unsigned buf_off_result(int unsigned n, int unsigned rw);
        return n + 3 * rw + CtlBits + FlagBits;
    endfunction

    function automatic int unsigned buf_width(int unsigned n, int unsigned rw);
        return 2 * n + 3 * rw + CtlBits + FlagBits;
    endfunction

endpackage

// File: rtl/exec_stage_mc_seq_mul.sv
// N-cycle radix-2 shift-add multiplier returning the low N product bits.
// Low N bits of a two's-complement product equal the unsigned product mod 2^N.
module seq_mul #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] p
);
    localparam int unsigned CW = $clog2(N);

    logic [N-1:0]  acc_q, mcand_q, mplier_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic [N-1:0]  acc_next;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = run_q && (cnt_q == CW'(N - 1));
        p        = acc_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (abort) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: forwarding, operand select, single-cycle ALU, multi-cycle multiply,
// and the EX/MEM pipeline buffer.
module exec_stage_mc
    import exec_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned RW = 4,
    parameter int unsigned BW = 2 * N + 3 * RW + 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [N-1:0]  rd1,
    input  logic [N-1:0]  rd2,
    input  logic [N-1:0]  pc,
    input  logic [N-1:0]  imm,
    input  logic [N-1:0]  aluOut,
    input  logic [N-1:0]  result,
    input  logic [N-1:0]  rd3,
    input  logic [3:0]    aluControl,
    input  logic [RW-1:0] Ra,
    input  logic [RW-1:0] Rb,
    input  logic [RW-1:0] Rc,
    input  logic          immSrc,
    input  logic          branchFlag,
    input  logic          memWrite,
    input  logic          memToReg,
    input  logic          regWrite,
    input  logic [1:0]    Fa,
    input  logic [1:0]    Fb,
    output logic          busy,
    output logic          out_valid,
    output logic [BW-1:0] bufferOut
);
    localparam int unsigned SW     = $clog2(N);
    localparam int unsigned HW     = N + 3 * RW + CtlBits;
    localparam int unsigned CtlOff = buf_off_ctl(N, RW);

    typedef enum logic [0:0] {StIdle, StMul} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic          valid_q, valid_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [N-1:0]  fwd_a, fwd_b, op_a, op_b, alu_res;
    logic [N:0]    add_w, sub_w;
    logic [SW-1:0] shamt;
    logic          alu_c, alu_v, is_mul;
    logic [HW-1:0] pt;
    logic          mul_start, mul_done;
    logic [N-1:0]  mul_p;

    always_comb begin
        case (fwd_sel_t'(Fa))
            FwdAlu:  fwd_a = aluOut;
            FwdRes:  fwd_a = result;
            default: fwd_a = rd1;
        endcase
        case (fwd_sel_t'(Fb))
            FwdAlu:  fwd_b = aluOut;
            FwdRes:  fwd_b = result;
            default: fwd_b = rd2;
        endcase
    end

    assign op_a   = branchFlag ? pc : fwd_a;
    assign op_b   = immSrc ? imm : fwd_b;
    assign shamt  = op_b[SW-1:0];
    assign add_w  = {1'b0, op_a} + {1'b0, op_b};
    // Carry-out of A + ~B + 1 is 1 when no borrow occurs.
    assign sub_w  = {1'b0, op_a} + {1'b0, ~op_b} + {{N{1'b0}}, 1'b1};
    assign is_mul = (alu_op_t'(aluControl) == OpMul);
    assign pt     = {branchFlag, memWrite, memToReg, regWrite, Ra, Rb, Rc, rd3};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op_t'(aluControl))
            OpSub, OpCmp: begin
                alu_res = sub_w[N-1:0];
                alu_c   = sub_w[N];
                alu_v   = (op_a[N-1] != op_b[N-1]) && (sub_w[N-1] != op_a[N-1]);
            end
            OpAdd: begin
                alu_res = add_w[N-1:0];
                alu_c   = add_w[N];
                alu_v   = (op_a[N-1] == op_b[N-1]) && (add_w[N-1] != op_a[N-1]);
            end
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
            OpShl:   alu_res = op_a << shamt;
            OpShr:   alu_res = op_a >> shamt;
            OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    seq_mul #(
        .N(N)
    ) u_seq_mul (
        .clk  (clk),
        .rst  (rst),
        .start(mul_start),
        .abort(flush),
        .a    (op_a),
        .b    (op_b),
        .done (mul_done),
        .p    (mul_p)
    );

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        valid_d   = valid_q;
        hold_d    = hold_q;
        mul_start = 1'b0;
        if (flush) begin
            state_d                  = StIdle;
            valid_d                  = 1'b0;
            buf_d[CtlOff +: CtlBits] = '0;
        end else if (state_q == StMul) begin
            if (mul_done) begin
                buf_d   = {mul_p, 1'b0, 1'b0, (mul_p == '0), mul_p[N-1], hold_q};
                valid_d = 1'b1;
                state_d = StIdle;
            end
        end else if (en) begin
            if (in_valid && is_mul) begin
                hold_d    = pt;
                mul_start = 1'b1;
                valid_d   = 1'b0;
                state_d   = StMul;
            end else begin
                buf_d   = {alu_res, alu_v, alu_c, (alu_res == '0), alu_res[N-1], pt};
                valid_d = in_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            buf_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign busy      = (state_q == StMul);
    assign out_valid = valid_q;
    assign bufferOut = buf_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Randomised self-checking bench for exec_stage_mc against an arithmetic reference model.
module tb_exec_stage_mc;
    localparam int N  = 8;
    localparam int RW = 4;
    localparam int BW = 2 * N + 3 * RW + 8;

    logic          clk = 1'b0;
    logic          rst, en, flush, in_valid;
    logic [N-1:0]  rd1, rd2, pc, imm, aluOut, result, rd3;
    logic [3:0]    aluControl;
    logic [RW-1:0] Ra, Rb, Rc;
    logic          immSrc, branchFlag, memWrite, memToReg, regWrite;
    logic [1:0]    Fa, Fb;
    logic          busy, out_valid;
    logic [BW-1:0] bufferOut;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exec_stage_mc #(
        .N (N),
        .RW(RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .rd1       (rd1),
        .rd2       (rd2),
        .pc        (pc),
        .imm       (imm),
        .aluOut    (aluOut),
        .result    (result),
        .rd3       (rd3),
        .aluControl(aluControl),
        .Ra        (Ra),
        .Rb        (Rb),
        .Rc        (Rc),
        .immSrc    (immSrc),
        .branchFlag(branchFlag),
        .memWrite  (memWrite),
        .memToReg  (memToReg),
        .regWrite  (regWrite),
        .Fa        (Fa),
        .Fb        (Fb),
        .busy      (busy),
        .out_valid (out_valid),
        .bufferOut (bufferOut)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        rd1 = '0; rd2 = '0; pc = '0; imm = '0; aluOut = '0; result = '0; rd3 = '0;
        aluControl = '0; Ra = '0; Rb = '0; Rc = '0;
        immSrc = 1'b0; branchFlag = 1'b0; memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
        Fa = '0; Fb = '0;
    endtask

    task automatic rand_fields();
        rd1 = N'($urandom); rd2 = N'($urandom); pc = N'($urandom); imm = N'($urandom);
        aluOut = N'($urandom); result = N'($urandom); rd3 = N'($urandom);
        Ra = RW'($urandom); Rb = RW'($urandom); Rc = RW'($urandom);
        immSrc = 1'($urandom); branchFlag = 1'($urandom); memWrite = 1'($urandom);
        memToReg = 1'($urandom); regWrite = 1'($urandom);
        Fa = 2'($urandom); Fb = 2'($urandom);
    endtask

    function automatic logic [N-1:0] pick(logic [1:0] s, logic [N-1:0] r);
        if (s == 2'd1) return aluOut;
        if (s == 2'd2) return result;
        return r;
    endfunction

    // Expected buffer for the instruction currently on the inputs.
    function automatic logic [BW-1:0] model();
        logic [N-1:0] a, b, res;
        int ua, ub, sa, sb, r, sh, mask, hi, lo;
        logic c, v;
        a = branchFlag ? pc : pick(Fa, rd1);
        b = immSrc ? imm : pick(Fb, rd2);
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        mask = (1 << N) - 1; hi = (1 << (N - 1)) - 1; lo = -(1 << (N - 1));
        sh = ub % N; c = 1'b0; v = 1'b0;
        case (aluControl)
            4'd0, 4'd4: begin
                r = ua - ub; c = (ua >= ub); v = (sa - sb > hi) || (sa - sb < lo);
            end
            4'd1: begin
                r = ua + ub; c = (r > mask); v = (sa + sb > hi) || (sa + sb < lo);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: r = ua << sh;
            4'd7: r = ua >> sh;
            4'd8: r = sa >>> sh;
            4'd9: r = sa * sb;
            default: r = 0;
        endcase
        r = r & mask;
        res = r[N-1:0];
        return {res, v, c, (res == '0), res[N-1], branchFlag, memWrite, memToReg, regWrite,
                Ra, Rb, Rc, rd3};
    endfunction

    task automatic test_reset();
        idle_inputs();
        rand_fields();
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; aluControl = 4'd9;
        step();
        step();
        checks++;
        if (bufferOut !== '0) begin
            errors++; $display("FAIL reset_buf: got %h expected 0", bufferOut);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_add();
        logic [BW-1:0] exp;
        idle_inputs();
        en = 1'b1; in_valid = 1'b1; aluControl = 4'd1; rd1 = 8'd2; rd2 = 8'd2;
        Ra = 4'd1; Rb = 4'd2; Rc = 4'd3; regWrite = 1'b1;
        exp = model();
        step();
        checks++;
        if (bufferOut !== exp) begin
            errors++; $display("FAIL add_buf: got %h expected %h", bufferOut, exp);
        end
        checks++;
        if (bufferOut[35:28] !== 8'd4 || bufferOut[25] !== 1'b0) begin
            errors++; $display("FAIL add_res: got %h z=%b expected 04 z=0",
                               bufferOut[35:28], bufferOut[25]);
        end
        checks++;
        if (bufferOut[19:8] !== 12'h123 || out_valid !== 1'b1) begin
            errors++; $display("FAIL add_regs: got %h v=%b expected 123 v=1",
                               bufferOut[19:8], out_valid);
        end
    endtask

    task automatic test_forward();
        idle_inputs();
        en = 1'b1; in_valid = 1'b1; aluControl = 4'd0;
        rd1 = 8'd5; aluOut = 8'd9; Fa = 2'b01; rd2 = 8'd0; result = 8'd4; Fb = 2'b10;
        step();
        checks++;
        if (bufferOut[35:28] !== 8'd5 || bufferOut[26] !== 1'b1) begin
            errors++; $display("FAIL fwd_sub: got %h c=%b expected 05 c=1",
                               bufferOut[35:28], bufferOut[26]);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        en = 1'b1; in_valid = 1'b1; aluControl = 4'd0; branchFlag = 1'b1; pc = 8'd1; rd2 = 8'd2;
        step();
        checks++;
        if (bufferOut[35:28] !== 8'hFF || bufferOut[24] !== 1'b1 || bufferOut[26] !== 1'b0) begin
            errors++; $display("FAIL branch_sub: got %h n=%b c=%b expected ff n=1 c=0",
                               bufferOut[35:28], bufferOut[24], bufferOut[26]);
        end
        branchFlag = 1'b0; aluControl = 4'd1; rd1 = 8'd127; rd2 = 8'd1;
        step();
        checks++;
        if (bufferOut[35:28] !== 8'h80 || bufferOut[27] !== 1'b1 || bufferOut[24] !== 1'b1) begin
            errors++; $display("FAIL add_ovf: got %h v=%b n=%b expected 80 v=1 n=1",
                               bufferOut[35:28], bufferOut[27], bufferOut[24]);
        end
    endtask

    task automatic test_mul();
        logic [BW-1:0] pre, exp;
        idle_inputs();
        en = 1'b1; in_valid = 1'b1; aluControl = 4'd1; rd1 = 8'h11; rd2 = 8'h22; Rc = 4'd5;
        pre = model();
        step();
        aluControl = 4'd9; rd1 = 8'hFD; rd2 = 8'd7; Ra = 4'd4; Rb = 4'd6; Rc = 4'd7;
        rd3 = 8'h5A; regWrite = 1'b1;
        exp = model();
        step();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || bufferOut !== pre) begin
            errors++; $display("FAIL mul_e0: got busy=%b v=%b buf=%h expected 1 0 %h",
                               busy, out_valid, bufferOut, pre);
        end
        for (int i = 1; i < N; i++) begin
            rand_fields();
            aluControl = 4'($urandom); in_valid = 1'($urandom); en = 1'($urandom);
            step();
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL mul_busy%0d: got busy=%b v=%b expected 1 0",
                                   i, busy, out_valid);
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || bufferOut !== exp) begin
            errors++; $display("FAIL mul_done: got busy=%b v=%b buf=%h expected 0 1 %h",
                               busy, out_valid, bufferOut, exp);
        end
        checks++;
        if (bufferOut[35:28] !== 8'hEB || bufferOut[24] !== 1'b1) begin
            errors++; $display("FAIL mul_value: got %h n=%b expected eb n=1",
                               bufferOut[35:28], bufferOut[24]);
        end
        idle_inputs();
    endtask

    task automatic test_flush_mul();
        logic [BW-1:0] exp;
        idle_inputs();
        rand_fields();
        en = 1'b1; in_valid = 1'b1; aluControl = 4'd9;
        regWrite = 1'b1; memToReg = 1'b1; memWrite = 1'b1; branchFlag = 1'b1;
        step();
        step();
        step();
        flush = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || bufferOut[23:20] !== 4'h0) begin
            errors++; $display("FAIL flush_mul: got busy=%b v=%b ctl=%h expected 0 0 0",
                               busy, out_valid, bufferOut[23:20]);
        end
        flush = 1'b0;
        rand_fields();
        aluControl = 4'd1;
        exp = model();
        step();
        checks++;
        if (bufferOut !== exp || out_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_then_add: got %h v=%b b=%b expected %h 1 0",
                               bufferOut, out_valid, busy, exp);
        end
        // Flush on the accept edge prevents the multiply from starting.
        flush = 1'b1; aluControl = 4'd9;
        step();
        flush = 1'b0; en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_accept: got busy=%b v=%b expected 0 0", busy, out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_rst_mid_mul();
        idle_inputs();
        rand_fields();
        en = 1'b1; in_valid = 1'b1; aluControl = 4'd9;
        step();
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bufferOut !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_mul: got %h v=%b b=%b expected 0 0 0",
                               bufferOut, out_valid, busy);
        end
        rst = 1'b1; en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_resume: got busy=%b expected 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] exp1, exp2;
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            rand_fields();
            en = 1'b1; in_valid = 1'b1; aluControl = 4'd9;
            exp1 = model();
            step();
            rand_fields();
            exp2 = model();
            for (int i = 1; i < N; i++) step();
            step();
            checks++;
            if (bufferOut !== exp1 || out_valid !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL b2b_first%0d: got %h v=%b b=%b expected %h 1 0",
                                   k, bufferOut, out_valid, busy, exp1);
            end
            step();
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_accept%0d: got busy=%b v=%b expected 1 0",
                                   k, busy, out_valid);
            end
            en = 1'b0;
            for (int i = 0; i < N; i++) step();
            checks++;
            if (bufferOut !== exp2 || out_valid !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL b2b_second%0d: got %h v=%b b=%b expected %h 1 0",
                                   k, bufferOut, out_valid, busy, exp2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [BW-1:0] exp_buf;
        logic          exp_valid, known, ctl_zero;
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_buf = '0; exp_valid = 1'b0; known = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rand_fields();
            flush = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 3) != 0);
            in_valid = 1'($urandom);
            aluControl = 4'($urandom_range(0, 15));
            if (aluControl == 4'd9 && in_valid) aluControl = 4'($urandom_range(0, 8));
            ctl_zero = 1'b0;
            if (flush) begin
                exp_valid = 1'b0; known = 1'b0; ctl_zero = 1'b1;
            end else if (en) begin
                if (aluControl == 4'd9) begin
                    exp_valid = 1'b0; known = 1'b0;
                end else begin
                    exp_buf = model(); exp_valid = in_valid; known = 1'b1;
                end
            end
            step();
            checks++;
            if (busy !== 1'b0 || out_valid !== exp_valid) begin
                errors++; $display("FAIL rand%0d_valid: got busy=%b v=%b expected 0 %b",
                                   i, busy, out_valid, exp_valid);
            end
            if (known) begin
                checks++;
                if (bufferOut !== exp_buf) begin
                    errors++; $display("FAIL rand%0d_buf: got %h expected %h op=%0d",
                                       i, bufferOut, exp_buf, aluControl);
                end
            end
            if (ctl_zero) begin
                checks++;
                if (bufferOut[23:20] !== 4'h0) begin
                    errors++; $display("FAIL rand%0d_flush_ctl: got %h expected 0",
                                       i, bufferOut[23:20]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_branch();
        test_mul();
        test_flush_mul();
        test_rst_mid_mul();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_stage_mc.md
# exec_stage_mc

Parametrised execute stage for the pipelined core. It resolves forwarded operands and selects immediates and the branch PC. It runs single-cycle ALU ops and a multi-cycle shift-add multiply, then registers the result, flags and pass-through control into the EX/MEM pipeline buffer. While a multiply is in flight it raises `busy` so the hazard unit can stall upstream stages.

## Interface
Parameters:
- `N`, 32: datapath width (≥4).
- `RW`, 4: register-index width.
- `BW`, 2*N+3*RW+8: buffer width. Derived; must not be overridden.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `en` in 1: advance enable from the hazard unit.
- `flush` in 1: insert bubble / abort.
- `in_valid` in 1: the ID/EX slot holds a real instruction.
- `rd1`, `rd2`, `pc`, `imm` in N: signed register operands, PC and immediate.
- `aluOut` in N: EX/MEM value for forwarding.
- `result` in N: WB value for forwarding.
- `rd3` in N: store data, passed through.
- `aluControl` in 4: operation code.
- `Ra`, `Rb`, `Rc` in RW: register indices, passed through.
- `immSrc`, `branchFlag`, `memWrite`, `memToReg`, `regWrite` in 1: decoded control.
- `Fa`, `Fb` in 2: forwarding selects.
- `busy` out 1: multiply in flight; stall request.
- `out_valid` out 1: `bufferOut` holds a real instruction.
- `bufferOut` out BW: EX/MEM buffer.

## Operation
- Forwarding for `Fa`/`Fb`:
  - 00 selects `rd1`/`rd2`.
  - 01 selects `aluOut`.
  - 10 selects `result`.
  - 11 is treated as 00.
- Operand A is `pc` if `branchFlag`=1, else the forwarded rd1.
- Operand B is `imm` if `immSrc`=1, else the forwarded rd2.
- `aluControl` encoding:
  - 0 SUB (A−B), 1 ADD, 2 AND, 3 OR, 4 CMP (A−B), 5 XOR.
  - 6 SHL, 7 SHR (logical), 8 SRA. Shift amount is B[$clog2(N)-1:0].
  - 9 MUL, low N bits, signed, multi-cycle.
  - 10–15 produce result 0.
- Flags:
  - zero = (result==0); neg = result[N-1].
  - ADD/SUB/CMP: carry = carry-out (SUB: 1 = no borrow); overflow = signed overflow.
  - All other ops, including MUL: carry = overflow = 0.
- `bufferOut` layout, LSB first: rd3[N], Rc, Rb, Ra, regWrite, memToReg, memWrite, branchFlag, neg, zero, carry, overflow, aluResult[N].
- Priority per edge: rst > flush > multiply-in-progress > en.
- Idle, `en`=1, op≠MUL: load the buffer from the current inputs; `out_valid`←`in_valid`.
- Idle, `en`=0: hold every register.
- MUL accepted (`en`=1, `in_valid`=1, op=9) at edge E0:
  - Latch the forwarded operands and all pass-through fields.
  - `busy`←1 and `out_valid`←0 at E0; `bufferOut` keeps its prior value.
- MUL iterations:
  - One iteration per edge, edges E1..EN.
  - At EN, load the buffer with the product and latched fields; `out_valid`←1, `busy`←0.
  - `en` and all inputs are ignored during E1..EN.
- `flush`=1 at any edge:
  - `out_valid`←0; regWrite, memToReg, memWrite, branchFlag fields ←0.
  - Any multiply is aborted and `busy`←0.
  - Other fields are don't-care but must be deterministic.
- A MUL with `in_valid`=0 is not started and is treated as a bubble.

## Timing
- Reset values: `bufferOut`=0, `out_valid`=0, `busy`=0. Internal multiplier state is cleared.
- Single-cycle ops: latency 1 edge.
- MUL: `busy` is high for exactly N cycles after E0. The result is visible after EN, so latency is N edges.
- `busy` is a registered output with no combinational path from inputs.
- A new instruction is accepted on the edge after `busy` falls; back-to-back MULs are allowed.
- `rst` low mid-multiply: all outputs go to reset values on that edge.
- `flush` and `rst` high on the same edge as a MUL accept: the flush wins, and no multiply starts.

## Structure
- Package `exec_pkg` holds:
  - the `alu_op_t` enum (values above) and the `fwd_sel_t` enum;
  - buffer field offset/width localparam functions of N and RW, shared with the MEM stage.
- Sub-module `seq_mul`: an N-cycle radix-2 shift-add signed multiplier.
  - Ports: clk, rst, start, abort, a, b, done, p.
  - Combinational ALU and muxes stay in the top.

## Test plan
Parameters N=8, RW=4.
1. Reset: hold `rst`=0 for 2 edges → `bufferOut`=0, `out_valid`=0, `busy`=0.
2. ADD rd1=2, rd2=2, Ra=1, Rb=2, Rc=3, Fa=Fb=00, `in_valid`=1 → after 1 edge: aluResult=4, zero=0, Ra/Rb/Rc fields 1/2/3, `out_valid`=1.
3. Forwarding: SUB, rd1=5, aluOut=9, Fa=01, rd2=0, result=4, Fb=10 → aluResult=5, carry=1.
4. Branch: SUB, `branchFlag`=1, pc=1, rd2=2 → aluResult=0xFF, neg=1, carry=0; ADD 127+1 → 0x80, overflow=1, neg=1.
5. MUL rd1=−3, rd2=7 → `busy`=1 for 8 cycles with `out_valid`=0; at E8 aluResult=0xEB, neg=1, `out_valid`=1, `busy`=0.
6. Flush at E3 of a MUL → next cycle `busy`=0, `out_valid`=0, control bits 0; the ADD presented on the following edge completes in 1 edge.
